// File: rtl/flash_read_arbiter.sv
// Two-requester arbiter in front of a SPI NOR flash: issues READ (0x03) + 24-bit address
// and streams the requested bytes back to the owner, with a power-up hold-off and CS gap.
module flash_read_arbiter #(
    parameter int unsigned STARTUP_DELAY = 2700000,
    parameter int unsigned CS_GAP        = 4
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [1:0]  i_req,
    input  logic [23:0] i_addr0,
    input  logic [23:0] i_addr1,
    input  logic [7:0]  i_len0,
    input  logic [7:0]  i_len1,
    input  logic        i_flashMISO,
    output logic        o_flashCLK,
    output logic        o_flashMOSI,
    output logic        o_flashCS,
    output logic [1:0]  o_gnt,
    output logic [7:0]  o_byte,
    output logic [1:0]  o_byteValid,
    output logic [1:0]  o_done,
    output logic        o_ready
);

    localparam int unsigned SW = (STARTUP_DELAY > 1) ? $clog2(STARTUP_DELAY) : 1;
    localparam int unsigned GW = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;

    typedef enum logic [2:0] {
        ST_STARTUP,
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DATA,
        ST_GAP
    } state_t;

    state_t      state_q, state_d;
    logic [SW-1:0] start_cnt_q, start_cnt_d;
    logic [GW-1:0] gap_cnt_q, gap_cnt_d;
    logic        phase_q, phase_d;
    logic [4:0]  bit_cnt_q, bit_cnt_d;
    logic [31:0] tx_q, tx_d;
    logic [6:0]  rx_q, rx_d;
    logic [8:0]  byte_cnt_q, byte_cnt_d;
    logic        rr_q, rr_d;
    logic [1:0]  gnt_q, gnt_d;
    logic [7:0]  byte_q, byte_d;
    logic [1:0]  byte_valid_q, byte_valid_d;
    logic [1:0]  done_q, done_d;
    logic        ready_q, ready_d;
    logic        cs_q, cs_d;
    logic        sclk_q, sclk_d;
    logic        mosi_q, mosi_d;
    logic        pick;
    logic [7:0]  pick_len;

    always_comb begin
        state_d      = state_q;
        start_cnt_d  = start_cnt_q;
        gap_cnt_d    = gap_cnt_q;
        phase_d      = phase_q;
        bit_cnt_d    = bit_cnt_q;
        tx_d         = tx_q;
        rx_d         = rx_q;
        byte_cnt_d   = byte_cnt_q;
        rr_d         = rr_q;
        gnt_d        = gnt_q;
        byte_d       = byte_q;
        byte_valid_d = 2'b00;
        done_d       = 2'b00;
        ready_d      = ready_q;
        cs_d         = cs_q;
        sclk_d       = sclk_q;
        mosi_d       = mosi_q;
        // rr_q names the requester that wins a tie; it always points away from the last owner
        pick         = (i_req == 2'b11) ? rr_q : i_req[1];
        pick_len     = pick ? i_len1 : i_len0;

        case (state_q)
            ST_STARTUP: begin
                if (start_cnt_q == SW'(STARTUP_DELAY - 1)) begin
                    state_d = ST_IDLE;
                    ready_d = 1'b1;
                end else begin
                    start_cnt_d = start_cnt_q + SW'(1);
                end
            end
            ST_IDLE: begin
                if (|i_req) begin
                    gnt_d      = pick ? 2'b10 : 2'b01;
                    rr_d       = ~pick;
                    tx_d       = {8'h03, (pick ? i_addr1 : i_addr0)};
                    byte_cnt_d = (pick_len == 8'd0) ? 9'd256 : {1'b0, pick_len};
                    cs_d       = 1'b0;
                    sclk_d     = 1'b0;
                    mosi_d     = 1'b0;
                    phase_d    = 1'b0;
                    bit_cnt_d  = 5'd0;
                    state_d    = ST_CMD;
                end
            end
            ST_CMD, ST_ADDR, ST_DATA: begin
                if (!phase_q) begin
                    phase_d = 1'b1;
                    sclk_d  = 1'b1;
                end else begin
                    phase_d   = 1'b0;
                    sclk_d    = 1'b0;
                    bit_cnt_d = bit_cnt_q + 5'd1;
                    if (state_q != ST_DATA) begin
                        tx_d   = {tx_q[30:0], 1'b0};
                        mosi_d = tx_q[30];
                        if (state_q == ST_CMD && bit_cnt_q == 5'd7)
                            state_d = ST_ADDR;
                        if (state_q == ST_ADDR && bit_cnt_q == 5'd31) begin
                            state_d   = ST_DATA;
                            mosi_d    = 1'b0;
                            bit_cnt_d = 5'd0;
                        end
                    end else begin
                        rx_d = {rx_q[5:0], i_flashMISO};
                        if (bit_cnt_q[2:0] == 3'd7) begin
                            byte_d       = {rx_q, i_flashMISO};
                            byte_valid_d = gnt_q;
                            byte_cnt_d   = byte_cnt_q - 9'd1;
                            if (byte_cnt_q == 9'd1) begin
                                done_d    = gnt_q;
                                gnt_d     = 2'b00;
                                cs_d      = 1'b1;
                                gap_cnt_d = '0;
                                state_d   = ST_GAP;
                            end
                        end
                    end
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == GW'(CS_GAP - 1))
                    state_d = ST_IDLE;
                else
                    gap_cnt_d = gap_cnt_q + GW'(1);
            end
            default: state_d = ST_STARTUP;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= ST_STARTUP;
            start_cnt_q  <= '0;
            gap_cnt_q    <= '0;
            phase_q      <= 1'b0;
            bit_cnt_q    <= 5'd0;
            tx_q         <= 32'd0;
            rx_q         <= 7'd0;
            byte_cnt_q   <= 9'd0;
            rr_q         <= 1'b0;
            gnt_q        <= 2'b00;
            byte_q       <= 8'd0;
            byte_valid_q <= 2'b00;
            done_q       <= 2'b00;
            ready_q      <= 1'b0;
            cs_q         <= 1'b1;
            sclk_q       <= 1'b0;
            mosi_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            start_cnt_q  <= start_cnt_d;
            gap_cnt_q    <= gap_cnt_d;
            phase_q      <= phase_d;
            bit_cnt_q    <= bit_cnt_d;
            tx_q         <= tx_d;
            rx_q         <= rx_d;
            byte_cnt_q   <= byte_cnt_d;
            rr_q         <= rr_d;
            gnt_q        <= gnt_d;
            byte_q       <= byte_d;
            byte_valid_q <= byte_valid_d;
            done_q       <= done_d;
            ready_q      <= ready_d;
            cs_q         <= cs_d;
            sclk_q       <= sclk_d;
            mosi_q       <= mosi_d;
        end
    end

    assign o_flashCLK  = sclk_q;
    assign o_flashMOSI = mosi_q;
    assign o_flashCS   = cs_q;
    assign o_gnt       = gnt_q;
    assign o_byte      = byte_q;
    assign o_byteValid = byte_valid_q;
    assign o_done      = done_q;
    assign o_ready     = ready_q;

endmodule

// File: tb/tb_flash_read_arbiter.sv
// Bench for flash_read_arbiter: behavioural SPI flash, round-robin model and per-transaction
// checks of command/address, returned bytes, CS-low length, gaps and reset behaviour.
module tb_flash_read_arbiter;
    localparam int D   = 10;
    localparam int GAP = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  i_req;
    logic [23:0] i_addr0, i_addr1;
    logic [7:0]  i_len0, i_len1;
    logic        i_flashMISO = 1'b0;
    logic        o_flashCLK, o_flashMOSI, o_flashCS, o_ready;
    logic [1:0]  o_gnt, o_byteValid, o_done;
    logic [7:0]  o_byte;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rr_m = 0;

    flash_read_arbiter #(.STARTUP_DELAY(D), .CS_GAP(GAP)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_req(i_req),
        .i_addr0(i_addr0), .i_addr1(i_addr1), .i_len0(i_len0), .i_len1(i_len1),
        .i_flashMISO(i_flashMISO), .o_flashCLK(o_flashCLK), .o_flashMOSI(o_flashMOSI),
        .o_flashCS(o_flashCS), .o_gnt(o_gnt), .o_byte(o_byte), .o_byteValid(o_byteValid),
        .o_done(o_done), .o_ready(o_ready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] flash_byte(input logic [23:0] a);
        case (a)
            24'h000100: return 8'hA5;
            24'h000101: return 8'h3C;
            24'h000102: return 8'hFF;
            default:    return 8'(a[7:0] * 8'd37) ^ a[15:8] ^ a[23:16] ^ 8'h5A;
        endcase
    endfunction

    // Flash model: captures 32 command/address bits on rising SCK, shifts data out on falling SCK
    int          fm_bits = 0;
    int          fm_k;
    logic [31:0] fm_sr = 32'd0;
    logic [7:0]  fm_op = 8'd0;
    logic [23:0] fm_addr = 24'd0;
    logic [7:0]  fm_b;

    always @(posedge o_flashCLK or posedge o_flashCS) begin
        if (o_flashCS) begin
            fm_bits = 0;
        end else begin
            fm_sr = {fm_sr[30:0], o_flashMOSI};
            fm_bits++;
            if (fm_bits == 32) begin
                fm_op   = fm_sr[31:24];
                fm_addr = fm_sr[23:0];
            end
        end
    end

    always @(negedge o_flashCLK) begin
        if (!o_flashCS && fm_bits >= 32) begin
            fm_k = fm_bits - 32;
            fm_b = flash_byte(fm_addr + 24'(fm_k / 8));
            i_flashMISO = fm_b[7 - (fm_k % 8)];
        end
    end

    task automatic do_txn(input logic [1:0] req, input bit drop,
                          output int gwait, output int gcyc, output int dcyc);
        int w, n, cs_low, got;
        bit seen, stray;
        logic [23:0] a;
        logic [7:0]  l;
        i_req = req;
        w = (req == 2'b11) ? rr_m : (req[1] ? 1 : 0);
        seen = 0; stray = 0; gwait = 0;
        while (!seen && gwait < 400) begin
            @(negedge clk);
            gwait++;
            if (o_gnt != 2'b00) seen = 1;
            else if (o_done != 2'b00 || o_byteValid != 2'b00 || !o_flashCS) stray = 1;
        end
        gcyc = cyc;
        check("grant", o_gnt, ((w == 1) ? 2'b10 : 2'b01));
        check("cs_low_at_grant", o_flashCS, 1'b0);
        rr_m = 1 - w;
        if (drop) i_req[w] = 1'b0;
        a = w ? i_addr1 : i_addr0;
        l = w ? i_len1 : i_len0;
        n = (l == 8'd0) ? 256 : int'(l);
        cs_low = 1; got = 0; seen = 0;
        for (int c = 0; c < 64 + 16 * n + 40 && !seen; c++) begin
            @(negedge clk);
            if (o_byteValid[w]) begin
                check("byte", o_byte, flash_byte(a + 24'(got)));
                got++;
            end
            if (o_byteValid[1 - w] || o_done[1 - w] || o_gnt[1 - w]) stray = 1;
            if (o_done[w]) seen = 1;
            else if (!o_flashCS) cs_low++;
        end
        dcyc = cyc;
        check("done_seen", seen, 1'b1);
        check("byte_count", got, n);
        check("cs_low_cycles", cs_low, 64 + 16 * n);
        check("done_latency", dcyc - gcyc, 64 + 16 * n);
        check("gnt_dropped_at_done", o_gnt, 2'b00);
        check("cs_high_at_done", o_flashCS, 1'b1);
        check("no_stray_strobe", stray, 1'b0);
        check("flash_opcode", fm_op, 8'h03);
        check("flash_addr", fm_addr, a);
        $display("txn req=%b owner=%0d addr=%06h len=%0d bytes=%0d cs_low=%0d", req, w, a, n, got, cs_low);
    endtask

    int gw, gc, dc, prev_dc, cnt, got2;
    bit bad;
    logic [1:0] nb;

    initial begin
        rst_n = 1'b0; i_req = 2'b00;
        i_addr0 = 24'd0; i_addr1 = 24'd0; i_len0 = 8'd0; i_len1 = 8'd0;
        repeat (3) @(negedge clk);
        check("rst_cs", o_flashCS, 1'b1);
        check("rst_sclk", o_flashCLK, 1'b0);
        check("rst_mosi", o_flashMOSI, 1'b0);
        check("rst_gnt", o_gnt, 2'b00);
        check("rst_bv", o_byteValid, 2'b00);
        check("rst_done", o_done, 2'b00);
        check("rst_byte", o_byte, 8'h00);
        check("rst_ready", o_ready, 1'b0);

        // Startup hold-off with requester 0 pending from reset; also the A5/3C/FF read
        i_req = 2'b01; i_addr0 = 24'h000100; i_len0 = 8'd3;
        rst_n = 1'b1;
        cnt = 0; bad = 0;
        while (!o_ready && cnt < 1000) begin
            @(negedge clk);
            cnt++;
            if (!o_flashCS || o_gnt != 2'b00) bad = 1;
        end
        check("startup_cycles", cnt, D);
        check("no_access_before_ready", bad, 1'b0);
        do_txn(2'b01, 1'b1, gw, gc, dc);
        check("grant_after_ready", gw, 1);
        prev_dc = dc;

        // Length zero means 256 bytes
        i_addr1 = 24'($urandom); i_len1 = 8'd0;
        do_txn(2'b10, 1'b1, gw, gc, dc);
        check("gap_len0", (gc - prev_dc) >= GAP + 1, 1'b1);
        prev_dc = dc;

        // Contention held on both: alternate grants
        i_addr0 = 24'($urandom); i_len0 = 8'($urandom_range(1, 4));
        i_addr1 = 24'($urandom); i_len1 = 8'($urandom_range(1, 4));
        for (int t = 0; t < 4; t++) begin
            do_txn(2'b11, 1'b0, gw, gc, dc);
            check("gap_contention", (gc - prev_dc) >= GAP + 1, 1'b1);
            prev_dc = dc;
        end
        i_req = 2'b00;

        // Random mix; a requester still waiting keeps its address and length
        for (int t = 0; t < 6; t++) begin
            nb = 2'($urandom_range(1, 3));
            if (nb[0] && !i_req[0]) begin i_addr0 = 24'($urandom); i_len0 = 8'($urandom_range(1, 6)); end
            if (nb[1] && !i_req[1]) begin i_addr1 = 24'($urandom); i_len1 = 8'($urandom_range(1, 6)); end
            do_txn(i_req | nb, 1'b1, gw, gc, dc);
            check("gap_random", (gc - prev_dc) >= GAP + 1, 1'b1);
            prev_dc = dc;
        end
        if (i_req != 2'b00) begin
            do_txn(i_req, 1'b1, gw, gc, dc);
            prev_dc = dc;
        end

        // Reset in the middle of DATA after two bytes
        i_addr0 = 24'($urandom); i_len0 = 8'd5; i_req = 2'b01;
        cnt = 0;
        while (o_gnt == 2'b00 && cnt < 400) begin @(negedge clk); cnt++; end
        check("abort_txn_grant", o_gnt, 2'b01);
        rr_m = 1;
        i_req = 2'b00;
        got2 = 0; cnt = 0;
        while (got2 < 2 && cnt < 400) begin
            @(negedge clk); cnt++;
            if (o_byteValid[0]) got2++;
        end
        check("abort_two_bytes", got2, 2);
        #2 rst_n = 1'b0;
        #1;
        check("abort_cs_async", o_flashCS, 1'b1);
        check("abort_gnt_async", o_gnt, 2'b00);
        check("abort_ready_async", o_ready, 1'b0);
        check("abort_byte_async", o_byte, 8'h00);
        rr_m = 0;
        i_req = 2'b11;
        bad = 0;
        repeat (3) begin @(negedge clk); if (o_done != 2'b00) bad = 1; end
        check("abort_no_done", bad, 1'b0);
        rst_n = 1'b1;
        do_txn(2'b11, 1'b1, gw, gc, dc);
        check("regrant_after_startup", gw, D + 1);
        do_txn(i_req, 1'b1, gw, gc, dc);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
